// File: rtl/controller_poller_pkg.sv
// Shared types and constants for the NES-style game pad poller.
package controller_pkg;

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/controller_poller_if.sv
// Pad pins plus the button-state handshake seen by downstream logic.
interface controller_poller_if;
  import controller_pkg::*;

  logic                   enable;
  logic                   poll_now;
  logic                   data;
  logic                   latch;
  logic                   pulse;
  logic [NUM_BUTTONS-1:0] buttons;
  logic                   buttons_valid;
  logic                   busy;

  modport master (
    input  enable, poll_now, data,
    output latch, pulse, buttons, buttons_valid, busy
  );

  modport slave (
    output enable, poll_now, data,
    input  latch, pulse, buttons, buttons_valid, busy
  );
endinterface

// File: rtl/controller_poller_sync_2ff.sv
// Two-flop synchronizer; resets to 1 so an unplugged/idle pad reads as not pressed.
module sync_2ff (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);
  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_reg <= 1'b1;
      q_reg    <= 1'b1;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/controller_poller.sv
// Periodic / on-demand sequencer that latches and shifts eight bits out of a game pad.
module controller_poller
  import controller_pkg::*;
#(
  parameter int LATCH_CYC   = 600,
  parameter int HALF_CYC    = 300,
  parameter int POLL_PERIOD = 833333
) (
  input logic clk,
  input logic n_rst,
  controller_poller_if.master bus
);
  localparam int CNT_W = $clog2(max_int(LATCH_CYC, HALF_CYC));
  localparam int TMR_W = $clog2(POLL_PERIOD);
  localparam int IDX_W = $clog2(NUM_BUTTONS);

  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BUTTONS - 1);

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [NUM_BUTTONS-1:0] frame_reg, frame_next;
  logic [TMR_W-1:0]       timer_reg;
  logic                   pending_reg;
  logic                   latch_reg, pulse_reg, busy_reg, valid_reg;
  logic [NUM_BUTTONS-1:0] buttons_reg;
  logic                   data_sync;
  logic                   timer_wrap;
  logic                   take;

  sync_2ff u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (bus.data),
    .q     (data_sync)
  );

  assign timer_wrap = (timer_reg == TMR_LAST);
  assign take       = (state_reg == IDLE) && pending_reg && bus.enable;

  // A new request wins over the clear, so a request landing on the start cycle still gets its own frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer_reg   <= '0;
      pending_reg <= 1'b0;
    end else if (!bus.enable) begin
      timer_reg   <= '0;
      pending_reg <= 1'b0;
    end else begin
      timer_reg <= timer_wrap ? '0 : timer_reg + TMR_W'(1);
      if (timer_wrap || bus.poll_now) begin
        pending_reg <= 1'b1;
      end else if (take) begin
        pending_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    frame_next = frame_reg;
    case (state_reg)
      IDLE: begin
        if (take) begin
          state_next = LATCH;
          cnt_next   = LATCH_LOAD;
        end
      end
      LATCH: begin
        if (cnt_reg == '0) begin
          state_next = LOW;
          cnt_next   = HALF_LOAD;
          idx_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_reg == '0) begin
          frame_next[idx_reg] = data_sync;
          state_next          = (idx_reg == IDX_LAST) ? DONE : HIGH;
          cnt_next            = HALF_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt_reg == '0) begin
          state_next = LOW;
          cnt_next   = HALF_LOAD;
          idx_next   = idx_reg + IDX_W'(1);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      frame_reg   <= '0;
      latch_reg   <= 1'b0;
      pulse_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      buttons_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      frame_reg <= frame_next;
      latch_reg <= (state_next == LATCH);
      pulse_reg <= (state_next == HIGH);
      busy_reg  <= (state_next != IDLE);
      valid_reg <= (state_next == DONE);
      if (state_next == DONE) begin
        buttons_reg <= ~frame_next;
      end
    end
  end

  assign bus.latch         = latch_reg;
  assign bus.pulse         = pulse_reg;
  assign bus.busy          = busy_reg;
  assign bus.buttons_valid = valid_reg;
  assign bus.buttons       = buttons_reg;
endmodule

// File: tb/tb_controller_poller.sv
// Bench for controller_poller: a pad model feeds a scoreboard checked at every buttons_valid.
module tb_controller_poller;
  import controller_pkg::*;

  localparam int LATCH_CYC   = 4;
  localparam int HALF_CYC    = 4;
  localparam int POLL_PERIOD = 200;
  localparam int FRAME_LEN   = LATCH_CYC + 15 * HALF_CYC;
  localparam int BOUND       = 400;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  controller_poller_if bus ();

  controller_poller #(
    .LATCH_CYC   (LATCH_CYC),
    .HALF_CYC    (HALF_CYC),
    .POLL_PERIOD (POLL_PERIOD)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pad: buttons pressed right now (1 = pressed); the pad reports them inverted on data.
  logic [7:0] pattern = 8'h89;
  logic [7:0] pad_sr  = 8'hFF;
  logic       pad_latch_prev = 1'b0;
  logic       pad_pulse_prev = 1'b0;
  logic [7:0] exp_q[$];

  assign bus.data = pad_sr[0];

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (bus.latch) begin
      pad_sr = ~pattern;
      if (!pad_latch_prev) exp_q.push_back(pattern);
    end else if (bus.pulse && !pad_pulse_prev) begin
      pad_sr = {1'b1, pad_sr[7:1]};
    end
    pad_latch_prev = bus.latch;
    pad_pulse_prev = bus.pulse;
  end

  // Monitor / scoreboard
  int         cyc = 0;
  int         latch_rise_cyc = 0;
  int         latch_hi = 0;
  int         pulse_rises = 0;
  int         valid_count = 0;
  int         latch_rises = 0;
  logic       mon_latch_prev = 1'b0;
  logic       mon_pulse_prev = 1'b0;
  logic       idle_seen = 1'b1;
  logic [7:0] buttons_prev = 8'h00;
  logic [7:0] want_b;

  always @(negedge clk) begin
    cyc++;
    if (!n_rst) begin
      exp_q.delete();
      mon_latch_prev = 1'b0;
      mon_pulse_prev = 1'b0;
      idle_seen      = 1'b1;
      buttons_prev   = 8'h00;
    end else begin
      check("latch_pulse_overlap", int'(bus.latch & bus.pulse), 0);
      if (bus.latch && !mon_latch_prev) begin
        latch_rises++;
        check("idle_between_frames", int'(idle_seen), 1);
        latch_rise_cyc = cyc;
        latch_hi       = 0;
        pulse_rises    = 0;
      end
      if (bus.latch) latch_hi++;
      if (bus.pulse && !mon_pulse_prev) pulse_rises++;
      if (!bus.busy) idle_seen = 1'b1;
      if (bus.buttons_valid) begin
        valid_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: buttons=0x%0h with no frame latched", bus.buttons);
        end else begin
          want_b = exp_q.pop_front();
          check("buttons", int'(bus.buttons), int'(want_b));
        end
        check("pulse_rises", pulse_rises, 7);
        check("latch_width", latch_hi, LATCH_CYC);
        check("frame_len", cyc - latch_rise_cyc, FRAME_LEN);
        idle_seen = 1'b0;
        $display("frame %0d: buttons=0x%02h at cycle %0d", valid_count, bus.buttons, cyc);
      end else begin
        check("buttons_hold", int'(bus.buttons), int'(buttons_prev));
      end
      buttons_prev   = bus.buttons;
      mon_latch_prev = bus.latch;
      mon_pulse_prev = bus.pulse;
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt = n_rst ? edge_cnt + 1 : 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_poll();
    bus.poll_now = 1'b1;
    tick();
    bus.poll_now = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin tick(); n++; end while (!bus.buttons_valid && n < BOUND);
    if (!bus.buttons_valid) begin
      checks++; errors++;
      $display("FAIL wait_valid: no buttons_valid within %0d cycles", n);
    end
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    do begin tick(); n++; end while (!bus.latch && n < BOUND);
    if (!bus.latch) begin
      checks++; errors++;
      $display("FAIL wait_latch: no latch within %0d cycles", n);
    end
  endtask

  task automatic wait_pulse();
    int n = 0;
    while (!bus.pulse && n < BOUND) begin tick(); n++; end
    if (!bus.pulse) begin
      checks++; errors++;
      $display("FAIL wait_pulse: no pulse within %0d cycles", n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < BOUND) begin tick(); n++; end
    if (bus.busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", n);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_latch"}, int'(bus.latch), 0);
    check({tag, "_pulse"}, int'(bus.pulse), 0);
    check({tag, "_buttons"}, int'(bus.buttons), 0);
    check({tag, "_valid"}, int'(bus.buttons_valid), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  int         n;
  int         lr0, v0;
  logic [7:0] mask_89;

  initial begin
    mask_89 = 8'((1 << BTN_A) | (1 << BTN_START) | (1 << BTN_RIGHT));
    bus.enable   = 1'b1;
    bus.poll_now = 1'b0;

    // Reset with enable high, then first automatic poll
    repeat (3) tick();
    check_all_low("reset");
    @(negedge clk);
    n_rst = 1'b1;
    wait_latch(n);
    check_range("first_latch_delay", n, POLL_PERIOD, POLL_PERIOD + 1);
    wait_valid(n);
    check("latch_to_valid", n, FRAME_LEN);
    check("decode_89", int'(bus.buttons), int'(mask_89));
    tick();
    check("valid_one_cycle", int'(bus.buttons_valid), 0);

    // Requested polls with directed corners then random patterns
    for (int i = 0; i < 10; i++) begin
      wait_idle();
      if (i == 0)      pattern = 8'h00;
      else if (i == 1) pattern = 8'hFF;
      else             pattern = 8'($urandom);
      pulse_poll();
      wait_valid(n);
      check((i == 0) ? "no_press" : "poll_result", int'(bus.buttons), int'(pattern));
    end

    // Collision: request on the timer terminal edge, then another mid-frame
    wait_idle();
    do tick(); while (edge_cnt % POLL_PERIOD != POLL_PERIOD - 1);
    lr0 = latch_rises;
    v0  = valid_count;
    pulse_poll();
    wait_latch(n);
    check("collision_latency", n, 1);
    repeat (20) tick();
    pulse_poll();
    wait_valid(n);
    wait_latch(n);
    check("back_to_back_gap", n, 2);
    wait_valid(n);
    repeat (30) tick();
    check("collision_frames", latch_rises - lr0, 2);
    check("collision_valids", valid_count - v0, 2);

    // Enable dropped mid-frame: frame completes, nothing afterwards
    wait_idle();
    pulse_poll();
    wait_latch(n);
    repeat (10) tick();
    bus.enable = 1'b0;
    wait_valid(n);
    check("enable_off_frame", int'(bus.buttons), int'(pattern));
    lr0 = latch_rises;
    for (int j = 0; j < 1000; j++) begin
      if (j == 100 || j == 600) pulse_poll();
      else tick();
    end
    check("enable_off_no_latch", latch_rises - lr0, 0);
    check("enable_off_busy", int'(bus.busy), 0);

    // Reset during a HIGH phase after a known frame
    bus.enable = 1'b1;
    wait_idle();
    pattern = mask_89;
    pulse_poll();
    wait_valid(n);
    check("prior_frame_89", int'(bus.buttons), int'(mask_89));
    wait_idle();
    pattern = 8'($urandom) | 8'h01;
    pulse_poll();
    wait_pulse();
    n_rst = 1'b0;
    #1;
    check_all_low("midframe_reset");
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    v0 = valid_count;
    repeat (150) tick();
    check("post_reset_no_valid", valid_count - v0, 0);
    check("post_reset_buttons", int'(bus.buttons), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/controller_poller.md
# controller_poller

Host-side sequencer for an NES-style serial game pad (8-bit parallel-in/serial-out shift register). On a periodic tick or an explicit request it drives `latch`, then clocks out eight bits with `pulse`, samples the active-low `data` line, and presents a registered, active-high 8-bit button vector with a one-cycle valid strobe. It sits between the pad GPIO pins and any logic that consumes button state, such as LEDs or game logic.

## Interface
- `LATCH_CYC`, default 600: latch high time in clocks (12 µs at 50 MHz); must be ≥ 4.
- `HALF_CYC`, default 300: pulse half-period in clocks (6 µs); must be ≥ 4.
- `POLL_PERIOD`, default 833333: clocks between automatic polls (about 60 Hz); must be > frame length.
- `clk` in 1: system clock (`CLOCK_50` at top level).
- `n_rst` in 1: asynchronous, active-low reset.
- `enable` in 1: allows automatic and requested polls.
- `poll_now` in 1: single-cycle request for an immediate poll.
- `data` in 1: serial data from the pad, active-low (0 = pressed), asynchronous.
- `latch` out 1: pad parallel-load strobe, active-high.
- `pulse` out 1: pad shift clock, active-high.
- `buttons` out 8: last completed frame, 1 = pressed; bit 0 is the first bit shifted out (A).
- `buttons_valid` out 1: one-cycle strobe when `buttons` updates.
- `busy` out 1: high while a frame is in progress (any state other than IDLE).

## Operation
- `data` passes through a 2-flop synchronizer before use.
- **Poll timer:** free-running counter, 0 to POLL_PERIOD−1, that counts only while `enable` = 1.
  - On reaching its terminal count it wraps and sets `pending`.
  - `poll_now` with `enable` = 1 also sets `pending`.
  - `pending` holds at most one request: the timer and `poll_now` firing together, or firing while busy, yield one poll.
  - `enable` = 0 clears `pending` and holds the timer at 0. A frame already in progress still completes.
- **FSM states:** IDLE, LATCH, LOW, HIGH, DONE.
  - IDLE → LATCH when `pending`; `pending` clears on this transition.
  - LATCH: `latch` = 1 for LATCH_CYC clocks, then → LOW with bit index 0.
  - LOW: `latch` = 0, `pulse` = 0 for HALF_CYC clocks.
    - On the last LOW cycle, the synchronized `data` is shifted into the frame register at the current bit index.
    - If the index is 7 → DONE; otherwise → HIGH.
  - HIGH: `pulse` = 1 for HALF_CYC clocks, then index increments and → LOW.
  - DONE, exactly one cycle: `buttons` ← ~frame register and `buttons_valid` = 1. Then → IDLE.
- `buttons` holds its value between frames and changes only in DONE.
- A single down-counter, width $clog2(max(LATCH_CYC, HALF_CYC)), times every state. A 3-bit counter tracks the bit index.

## Timing
- Reset values: `latch` 0, `pulse` 0, `buttons` 8'h00, `buttons_valid` 0, `busy` 0, FSM IDLE, timer 0, `pending` 0.
- Asynchronous reset mid-frame aborts immediately and leaves no partial update of `buttons`.
- Frame length from LATCH entry to DONE entry: LATCH_CYC + 15·HALF_CYC clocks (8 LOW periods and 7 HIGH periods).
- Exactly 7 rising edges of `pulse` per frame.
- `latch` and `pulse` are registered outputs, glitch-free, and never high at the same time.
- `poll_now` accepted in IDLE: LATCH entered on the next clock after `pending` is set (2-cycle request-to-`latch` latency).
- Each bit is sampled ≥ HALF_CYC−2 clocks after the preceding `pulse` edge, which covers synchronizer delay.
- Back-to-back requests: IDLE is always occupied for at least one cycle between frames.

## Structure
- Package `controller_pkg` contains:
  - `state_t` enum (IDLE, LATCH, LOW, HIGH, DONE);
  - `NUM_BUTTONS` = 8;
  - bit-index constants BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7.
- One sub-module, `sync_2ff`: a 1-bit two-flop synchronizer with async active-low reset, reset value 1 (idle/not-pressed).
- Everything else lives in `controller_poller`.

## Test plan
Simulation uses LATCH_CYC=4, HALF_CYC=4, POLL_PERIOD=200.
- **Reset:** assert `n_rst`=0 with `enable`=1 → all outputs 0; release → first `latch` rises after 200 clocks.
- **Frame decode:** pad model returns A, START, RIGHT pressed (data bits 0,3,7 low) → `buttons`=8'h89 and one `buttons_valid` strobe; 7 `pulse` rises; `latch` high exactly 4 cycles; DONE entered 64 clocks after LATCH entry.
- **No press:** `data` held 1 → `buttons`=8'h00 and `buttons_valid` strobes.
- **Collision:** `poll_now` on the same cycle as the timer terminal → exactly one frame. `poll_now` again mid-frame → exactly one more frame immediately after, with ≥ 1 IDLE cycle between.
- **Enable off:** `enable`=0 mid-frame → frame completes and updates `buttons`; no further `latch` for 1000 clocks; `poll_now` ignored.
- **Reset mid-frame:** `buttons`=8'h89 from a prior frame, `n_rst` pulsed low during HIGH → `latch`/`pulse` drop immediately, `buttons`=8'h00, no `buttons_valid`.
